// File: rtl/seg7_scan_if.sv
// Bus between the counter datapath and the 7-segment scan controller.
// The master side supplies the value, strobe and enable; the slave side drives the display pins.
interface seg7_scan_if;
    logic [15:0] din;
    logic        din_valid;
    logic        en;
    logic [6:0]  oSEG;
    logic [3:0]  light;
    logic        frame_start;

    modport master (
        output din, din_valid, en,
        input  oSEG, light, frame_start
    );

    modport slave (
        input  din, din_valid, en,
        output oSEG, light, frame_start
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit, common-anode, active-low 7-segment display.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   shadow;
    logic [15:0]   pending;
    logic          pend;
    logic          enPrev;
    logic [6:0]    segReg;
    logic [3:0]    lightReg;
    logic          frameStartReg;

    logic          enRise;
    logic          cntWrap;
    logic          boundary;
    logic          inBlank;
    logic          leadZero;
    logic [3:0]    nibble;

    function automatic logic [6:0] hexToSeg(input logic [3:0] h);
        case (h)
            4'h0:    hexToSeg = 7'h40;
            4'h1:    hexToSeg = 7'h79;
            4'h2:    hexToSeg = 7'h24;
            4'h3:    hexToSeg = 7'h30;
            4'h4:    hexToSeg = 7'h19;
            4'h5:    hexToSeg = 7'h12;
            4'h6:    hexToSeg = 7'h02;
            4'h7:    hexToSeg = 7'h78;
            4'h8:    hexToSeg = 7'h00;
            4'h9:    hexToSeg = 7'h18;
            4'hA:    hexToSeg = 7'h08;
            4'hB:    hexToSeg = 7'h03;
            4'hC:    hexToSeg = 7'h46;
            4'hD:    hexToSeg = 7'h21;
            4'hE:    hexToSeg = 7'h06;
            default: hexToSeg = 7'h0E;
        endcase
    endfunction

    // A rising enable restarts the scan and is treated as a frame boundary.
    assign enRise   = bus.en & ~enPrev;
    assign cntWrap  = (cnt == CW'(REFRESH_DIV - 1));
    assign boundary = enRise | (bus.en & cntWrap & (idx == 2'd3));
    assign nibble   = shadow[{idx, 2'b00} +: 4];

    generate
        if (BLANK_CYCLES == 0) begin : gNoBlank
            assign inBlank = 1'b0;
        end else begin : gBlank
            assign inBlank = (cnt < CW'(BLANK_CYCLES));
        end
    endgenerate

`ifdef SEG7_LZB_EN
    assign leadZero = (idx != 2'd0) && ((shadow >> {idx, 2'b00}) == 16'h0000);
`else
    assign leadZero = 1'b0;
`endif

    // Data capture, frame-aligned shadow update, slot counters and registered pin drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            idx           <= 2'd0;
            shadow        <= 16'h0000;
            pending       <= 16'h0000;
            pend          <= 1'b0;
            enPrev        <= 1'b0;
            segReg        <= 7'h7F;
            lightReg      <= 4'hF;
            frameStartReg <= 1'b0;
        end else begin
            enPrev <= bus.en;

            if (bus.din_valid) begin
                pending <= bus.din;
            end

            if (boundary && bus.din_valid) begin
                shadow <= bus.din;
                pend   <= 1'b0;
            end else if (boundary && pend) begin
                shadow <= pending;
                pend   <= 1'b0;
            end else if (bus.din_valid) begin
                pend   <= 1'b1;
            end

            if (!bus.en || enRise) begin
                cnt <= '0;
                idx <= 2'd0;
            end else if (cntWrap) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            // The restart cycle after enable rises stays dark so the new shadow is shown from slot 0.
            if (!bus.en || enRise) begin
                segReg        <= 7'h7F;
                lightReg      <= 4'hF;
                frameStartReg <= 1'b0;
            end else begin
                frameStartReg <= (cnt == '0) && (idx == 2'd0);
                if (inBlank || leadZero) begin
                    segReg   <= 7'h7F;
                    lightReg <= 4'hF;
                end else begin
                    segReg   <= hexToSeg(nibble);
                    lightReg <= ~(4'b0001 << idx);
                end
            end
        end
    end

    assign bus.oSEG        = segReg;
    assign bus.light       = lightReg;
    assign bus.frame_start = frameStartReg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with a frame-position reference model.
// Define SEG7_LZB_EN for both RTL and bench to check the leading-zero blanking build.
module tb_seg7_scan_ctrl;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic clk = 1'b0;
    logic rst;

    seg7_scan_if bus ();

    seg7_scan_ctrl #(
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;

    // Model: position inside the 4-digit frame, displayed value and pending value.
    int          mPos;
    logic        mEnWas;
    logic [15:0] mShown;
    logic [15:0] mPendVal;
    logic        mPendFlag;
    logic [6:0]  expSeg;
    logic [3:0]  expLight;
    logic        expFs;

    logic [6:0] segLut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic digitDark(input int digit, input logic [15:0] v);
`ifdef SEG7_LZB_EN
        return (digit > 0) && ((v >> (4 * digit)) == 16'h0000);
`else
        return 1'b0;
`endif
    endfunction

    task automatic modelReset();
        mPos      = 0;
        mEnWas    = 1'b0;
        mShown    = 16'h0000;
        mPendVal  = 16'h0000;
        mPendFlag = 1'b0;
        expSeg    = 7'h7F;
        expLight  = 4'hF;
        expFs     = 1'b0;
    endtask

    task automatic modelStep();
        logic rise;
        logic bnd;
        int   digit;
        int   off;
        rise  = bus.en && !mEnWas;
        bnd   = rise || (bus.en && (mPos == FRAME - 1));
        digit = mPos / DIV;
        off   = mPos % DIV;
        if (!bus.en || rise) begin
            expSeg   = 7'h7F;
            expLight = 4'hF;
            expFs    = 1'b0;
        end else begin
            expFs = (mPos == 0);
            if (off < BLANK || digitDark(digit, mShown)) begin
                expSeg   = 7'h7F;
                expLight = 4'hF;
            end else begin
                expSeg   = segLut[int'((mShown >> (4 * digit)) & 16'h000F)];
                expLight = 4'hF ^ (4'b0001 << digit);
            end
        end
        if (bnd && bus.din_valid) begin
            mShown    = bus.din;
            mPendFlag = 1'b0;
        end else if (bnd && mPendFlag) begin
            mShown    = mPendVal;
            mPendFlag = 1'b0;
        end else if (bus.din_valid) begin
            mPendVal  = bus.din;
            mPendFlag = 1'b1;
        end
        mPos   = (!bus.en || rise) ? 0 : (mPos + 1) % FRAME;
        mEnWas = bus.en;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkPins(input string tag);
        checkOutput({tag, ".oSEG"}, {9'd0, bus.oSEG}, {9'd0, expSeg});
        checkOutput({tag, ".light"}, {12'd0, bus.light}, {12'd0, expLight});
        checkOutput({tag, ".frame_start"}, {15'd0, bus.frame_start}, {15'd0, expFs});
        checkOutput({tag, ".onehot"}, {15'd0, ($countones(~bus.light) <= 1)}, 16'd1);
    endtask

    task automatic applyStimulus(input logic e, input logic dv, input logic [15:0] d, input string tag);
        bus.en        = e;
        bus.din_valid = dv;
        bus.din       = d;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        bus.din_valid = 1'b0;
        checkPins(tag);
    endtask

    task automatic runIdle(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 16'h0000, tag);
    endtask

    int bound;

    initial begin
        bus.en        = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = 16'h0000;
        rst           = 1'b1;
        modelReset();
        @(negedge clk);
        checkPins("reset");
        checkOutput("reset.pend", {15'd0, dut.pend}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Startup frame shows 0000, then park mid-SHOW with a pending strobe and reset asynchronously.
        runIdle(FRAME + 4, "boot");
        applyStimulus(1'b1, 1'b1, 16'h5555, "preRst");
        bound = 0;
        while (!((mPos % DIV) >= BLANK + 1) && bound < 100) begin
            runIdle(1, "seekShow");
            bound++;
        end
        checkOutput("seekShow.bound", {15'd0, ((mPos % DIV) >= BLANK + 1)}, 16'd1);
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkPins("asyncRst");
        checkOutput("asyncRst.pend", {15'd0, dut.pend}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        runIdle(FRAME + 2, "postRst");

        // Load 1234 and watch full frames.
        applyStimulus(1'b1, 1'b1, 16'h1234, "load1234");
        runIdle(2 * FRAME, "show1234");

        // Mid-frame strobe must not tear the frame in progress.
        bound = 0;
        while (mPos != DIV + 3 && bound < 100) begin
            runIdle(1, "seekMid");
            bound++;
        end
        checkOutput("seekMid.bound", {15'd0, (mPos == DIV + 3)}, 16'd1);
        applyStimulus(1'b1, 1'b1, 16'hABCD, "loadABCD");
        runIdle(2 * FRAME, "showABCD");

        // Strobe exactly on the wrap cycle is bypassed straight into the shadow.
        bound = 0;
        while (mPos != FRAME - 1 && bound < 100) begin
            runIdle(1, "seekWrap");
            bound++;
        end
        checkOutput("seekWrap.bound", {15'd0, (mPos == FRAME - 1)}, 16'd1);
        applyStimulus(1'b1, 1'b1, 16'h00FF, "bypass00FF");
        checkOutput("bypass.pend", {15'd0, dut.pend}, 16'd0);
        runIdle(FRAME + 1, "show00FF");

        // Disable during digit 2, stay off five cycles, then re-enable.
        bound = 0;
        while ((mPos / DIV) != 2 && bound < 100) begin
            runIdle(1, "seekDig2");
            bound++;
        end
        checkOutput("seekDig2.bound", {15'd0, ((mPos / DIV) == 2)}, 16'd1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 16'h0000, "enOff");
        runIdle(FRAME + 3, "enOn");

        // Leading zeros.
        applyStimulus(1'b1, 1'b1, 16'h0007, "load0007");
        runIdle(2 * FRAME, "show0007");

        // Randomized traffic, including strobes while disabled.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 19) != 0), ($urandom_range(0, 9) == 0),
                          16'($urandom), "random");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
